// File: rtl/exp_arbiter.sv
// Shares one exponential unit among NUM_REQ requesters: one accept/cycle, result EXP_LATENCY+1 cycles after accept, no response backpressure.
// Grant is round-robin by default; defining EXP_ARB_FIXED_PRIORITY_EN selects fixed priority (lowest index wins).
module exp_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int EXP_LATENCY    = 2,
  parameter int EXPONENT_WIDTH = 8,
  parameter int MANTISSA_WIDTH = 23,
  localparam int W             = 1 + EXPONENT_WIDTH + MANTISSA_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ*W-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [W-1:0]         exp_in,
  input  logic [W-1:0]         exp_out,
  output logic [NUM_REQ-1:0]   rsp_valid,
  output logic [W-1:0]         rsp_data,
  output logic [3:0]           inflight_cnt
);

  localparam int IDW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int STAGES = EXP_LATENCY + 1;

  logic           gnt_vld;
  logic [IDW-1:0] gnt_id;
  logic           accept;

  logic [W-1:0]   exp_in_q, exp_in_d;
  logic [W-1:0]   rsp_data_q, rsp_data_d;
  logic [3:0]     cnt_q, cnt_d;
  logic [STAGES-1:0] tag_vld_q;
  logic [IDW-1:0] tag_id_q [STAGES];

  logic           last_vld;
  logic [IDW-1:0] last_id;

`ifdef EXP_ARB_FIXED_PRIORITY_EN
  always_comb begin
    gnt_vld = 1'b0;
    gnt_id  = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        gnt_vld = 1'b1;
        gnt_id  = IDW'(i);
      end
    end
  end
`else
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [IDW-1:0] rr_idx;

  // Descending scan so the last hit, i.e. the one nearest the pointer, wins.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_id  = '0;
    rr_idx  = '0;
    for (int off = NUM_REQ - 1; off >= 0; off--) begin
      rr_idx = IDW'((int'(ptr_q) + off) % NUM_REQ);
      if (req_valid[rr_idx]) begin
        gnt_vld = 1'b1;
        gnt_id  = rr_idx;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (accept) begin
      ptr_d = (gnt_id == IDW'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`endif

  assign req_ready = (gnt_vld && rst_n) ? (NUM_REQ'(1) << gnt_id) : '0;
  assign accept    = |(req_valid & req_ready);

  assign last_vld  = tag_vld_q[STAGES-1];
  assign last_id   = tag_id_q[STAGES-1];

  always_comb begin
    exp_in_d   = exp_in_q;
    rsp_data_d = rsp_data_q;
    cnt_d      = cnt_q;
    if (accept) begin
      exp_in_d = req_data[int'(gnt_id)*W +: W];
    end
    if (last_vld) begin
      rsp_data_d = exp_out;
    end
    case ({accept, last_vld})
      2'b10:   cnt_d = cnt_q + 4'd1;
      2'b01:   cnt_d = cnt_q - 4'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Tag pipe runs in lockstep with the unit; exp_out lines up with the last stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_in_q   <= '0;
      rsp_data_q <= '0;
      cnt_q      <= '0;
      tag_vld_q  <= '0;
      for (int s = 0; s < STAGES; s++) begin
        tag_id_q[s] <= '0;
      end
    end else begin
      exp_in_q    <= exp_in_d;
      rsp_data_q  <= rsp_data_d;
      cnt_q       <= cnt_d;
      tag_vld_q   <= {tag_vld_q[STAGES-2:0], accept};
      tag_id_q[0] <= gnt_id;
      for (int s = 1; s < STAGES; s++) begin
        tag_id_q[s] <= tag_id_q[s-1];
      end
    end
  end

  assign exp_in       = exp_in_q;
  assign rsp_valid    = last_vld ? (NUM_REQ'(1) << last_id) : '0;
  assign rsp_data     = last_vld ? exp_out : rsp_data_q;
  assign inflight_cnt = cnt_q;

endmodule

// File: tb/tb_exp_arbiter.sv
// Directed bench for exp_arbiter (NUM_REQ=4, EXP_LATENCY=2) with a behavioural 2-cycle exponential unit.
module tb_exp_arbiter;
  localparam int N = 4;
  localparam int L = 2;
  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_ready;
  logic [W-1:0]   exp_in;
  logic [W-1:0]   exp_out;
  logic [N-1:0]   rsp_valid;
  logic [W-1:0]   rsp_data;
  logic [3:0]     inflight_cnt;

  int n_vec = 0;
  int n_err = 0;

  logic [3:0] g_rst [3];
  logic [3:0] g_all [8];
  logic [3:0] g_03  [6];

  exp_arbiter #(.NUM_REQ(N), .EXP_LATENCY(L)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .exp_in       (exp_in),
    .exp_out      (exp_out),
    .rsp_valid    (rsp_valid),
    .rsp_data     (rsp_data),
    .inflight_cnt (inflight_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] fexp(input logic [31:0] x);
    return (x == 32'h4000_0000) ? 32'h40EC_7326 : (x ^ 32'hA5A5_A5A5);
  endfunction

  function automatic logic [31:0] dval(input int i);
    return 32'h3F00_0010 + 32'(i);
  endfunction

  function automatic int oh2id(input logic [3:0] oh);
    for (int i = 0; i < 4; i++) if (oh[i]) return i;
    return 0;
  endfunction

  // Behavioural exponential unit: fixed two-cycle delay.
  logic [W-1:0] dly1, dly2;
  always @(posedge clk) begin
    dly1 <= exp_in;
    dly2 <= dly1;
  end
  assign exp_out = fexp(dly2);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
`ifdef EXP_ARB_FIXED_PRIORITY_EN
    g_rst = '{4'b0001, 4'b0001, 4'b0001};
    g_all = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
    g_03  = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
`else
    g_rst = '{4'b1000, 4'b0001, 4'b0010};
    g_all = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
    g_03  = '{4'b1000, 4'b0001, 4'b1000, 4'b0001, 4'b1000, 4'b0001};
`endif

    // Reset state, including grant suppression while reset is held.
    rst_n = 1'b0;
    req_valid = '0;
    req_data = '0;
    #1;
    req_valid = '1;
    #1;
    chk("rst_ready", req_ready, 0);
    chk("rst_rspv", rsp_valid, 0);
    chk("rst_cnt", inflight_cnt, 0);
    chk("rst_expin", exp_in, 0);
    chk("rst_rspd", rsp_data, 0);
    req_valid = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Single request from requester 2: e^2.
    req_data[2*W +: W] = 32'h4000_0000;
    req_valid = 4'b0100;
    #1;
    chk("t1_ready", req_ready, 4'b0100);
    cyc();
    req_valid = '0;
    chk("t1_expin", exp_in, 32'h4000_0000);
    chk("t1_cnt_c1", inflight_cnt, 1);
    chk("t1_rspv_c1", rsp_valid, 0);
    cyc();
    chk("t1_rspv_c2", rsp_valid, 0);
    cyc();
    chk("t1_rspv_c3", rsp_valid, 4'b0100);
    chk("t1_rspd_c3", rsp_data, 32'h40EC_7326);
    chk("t1_cnt_c3", inflight_cnt, 1);
    cyc();
    chk("t1_rspv_c4", rsp_valid, 0);
    chk("t1_rspd_hold", rsp_data, 32'h40EC_7326);
    chk("t1_cnt_c4", inflight_cnt, 0);

    // Three operations in flight, then asynchronous reset.
    for (int i = 0; i < N; i++) req_data[i*W +: W] = dval(i);
    req_valid = '1;
    for (int j = 0; j < 3; j++) begin
      #1;
      chk("mid_gnt", req_ready, g_rst[j]);
      cyc();
    end
    chk("mid_cnt3", inflight_cnt, 3);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_rspv", rsp_valid, 0);
    chk("mid_rst_cnt", inflight_cnt, 0);
    chk("mid_rst_ready", req_ready, 0);
    chk("mid_rst_rspd", rsp_data, 0);
    chk("mid_rst_expin", exp_in, 0);
    repeat (2) begin
      cyc();
      chk("in_rst_rspv", rsp_valid, 0);
    end
    req_valid = '0;
    rst_n = 1'b1;
    repeat (4) begin
      cyc();
      chk("post_rst_rspv", rsp_valid, 0);
      chk("post_rst_cnt", inflight_cnt, 0);
    end

    // All four requesters continuously valid; pointer restarts at 0.
    req_valid = '1;
    for (int j = 0; j < 12; j++) begin
      if (j == 8) req_valid = '0;
      #1;
      if (j < 8) chk("all_gnt", req_ready, g_all[j]);
      else       chk("all_gnt_idle", req_ready, 0);
      chk("all_cnt", inflight_cnt, (j < 3) ? j : ((j < 8) ? 3 : 11 - j));
      if (j >= 3 && j < 11) begin
        chk("all_rspv", rsp_valid, g_all[j-3]);
        chk("all_rspd", rsp_data, fexp(dval(oh2id(g_all[j-3]))));
      end else begin
        chk("all_rspv_idle", rsp_valid, 0);
      end
      if (j >= 1 && j < 9) chk("all_expin", exp_in, dval(oh2id(g_all[j-1])));
      cyc();
    end

    // Requester 1 pulses for one cycle while requester 0 holds valid.
    for (int c = 0; c < 8; c++) begin
      if (c < 4) begin
        req_valid = (c == 0) ? 4'b0011 : 4'b0001;
        req_data[0 +: W] = 32'h3E00_0000 + 32'(c);
      end else begin
        req_valid = '0;
      end
      #1;
      chk("wd_ready", req_ready, (c < 4) ? 4'b0001 : 4'b0000);
      chk("wd_cnt", inflight_cnt, (c < 4) ? c : 7 - c);
      if (c >= 3 && c < 7) begin
        chk("wd_rspv", rsp_valid, 4'b0001);
        chk("wd_rspd", rsp_data, fexp(32'h3E00_0000 + 32'(c - 3)));
      end else begin
        chk("wd_rspv_idle", rsp_valid, 0);
      end
      cyc();
    end

    // Requesters 0 and 3 continuously valid.
    for (int j = 0; j < 10; j++) begin
      req_valid = (j < 6) ? 4'b1001 : 4'b0000;
      #1;
      if (j < 6) chk("p03_gnt", req_ready, g_03[j]);
      chk("p03_cnt", inflight_cnt, (j < 3) ? j : ((j < 6) ? 3 : 9 - j));
      chk("p03_rspv", rsp_valid, (j >= 3 && j < 9) ? g_03[j-3] : 4'b0000);
      cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
